// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart transmit arbiter: FSM encoding and parameter defaults.
package uart_arb_pkg;

    localparam int NUM_REQ_DEF      = 4;
    localparam int BUSY_TIMEOUT_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit strictly after last_i, wrapping.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    output logic [IDW-1:0]     idx_o,
    output logic               vld_o
);

    logic [IDW-1:0] cand;

    always_comb begin
        idx_o = '0;
        vld_o = |req_i;
        cand  = '0;
        // walk from farthest to nearest so the nearest set bit after last_i is written last
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDW'((int'(last_i) + k) % NUM_REQ);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among NUM_REQ byte requesters with round-robin arbitration.
// Grant to trigger/ack is one cycle; requests wait while the transmitter is busy.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ      = NUM_REQ_DEF,
    parameter int  BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    localparam int IDW          = id_width(NUM_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic                   tx_busy_i,
    output logic                   tx_start_trigger_o,
    output logic [7:0]             tx_data_o,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [IDW-1:0]         grant_id_o,
    output logic                   active_o,
    output logic                   err_timeout_o,
    output logic [15:0]            byte_count_o
);

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               trig_q, trig_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               active_q, active_d;
    logic               err_q, err_d;
    logic [15:0]        byte_count_q, byte_count_d;
    logic [15:0]        tmo_q, tmo_d;

    logic [IDW-1:0]     pick_idx;
    logic               pick_vld;
    logic               grant_now;
    logic               timeout_hit;
    logic               frame_done;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i  (req_i),
        .last_i (grant_q),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    assign grant_now   = (state_q == S_IDLE) && pick_vld && !tx_busy_i;
    // tmo_q already counts the ISSUE cycle, so the limit lands BUSY_TIMEOUT cycles after the trigger
    assign timeout_hit = (state_q == S_WAIT_BUSY) && !tx_busy_i && (tmo_q >= 16'(BUSY_TIMEOUT - 1));
    assign frame_done  = (state_q == S_WAIT_DONE) && !tx_busy_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            grant_q      <= IDW'(NUM_REQ - 1);
            tx_data_q    <= '0;
            trig_q       <= 1'b0;
            ack_q        <= '0;
            active_q     <= 1'b0;
            err_q        <= 1'b0;
            byte_count_q <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            tx_data_q    <= tx_data_d;
            trig_q       <= trig_d;
            ack_q        <= ack_d;
            active_q     <= active_d;
            err_q        <= err_d;
            byte_count_q <= byte_count_d;
            tmo_q        <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (grant_now) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (tx_busy_i)        state_d = S_WAIT_DONE;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_WAIT_DONE: if (!tx_busy_i) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trig_d       = grant_now;
        ack_d        = '0;
        grant_d      = grant_q;
        tx_data_d    = tx_data_q;
        active_d     = (state_d != S_IDLE);
        err_d        = err_q | timeout_hit;
        byte_count_d = byte_count_q + {15'd0, frame_done};
        tmo_d        = '0;
        if (grant_now) begin
            ack_d[pick_idx] = 1'b1;
            grant_d         = pick_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick_idx == IDW'(i)) begin
                    tx_data_d = req_data_i[8*i +: 8];
                end
            end
        end
        case (state_q)
            S_ISSUE:     tmo_d = 16'd1;
            S_WAIT_BUSY: tmo_d = tmo_q + 16'd1;
            default:     tmo_d = '0;
        endcase
    end

    assign tx_start_trigger_o = trig_q;
    assign tx_data_o          = tx_data_q;
    assign ack_o              = ack_q;
    assign grant_id_o         = grant_q;
    assign active_o           = active_q;
    assign err_timeout_o      = err_q;
    assign byte_count_o       = byte_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios followed by randomized traffic against a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int NB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] req_data;
    logic            tx_busy;
    logic            trig;
    logic [7:0]      tx_data;
    logic [NR-1:0]   ack;
    logic [1:0]      grant_id;
    logic            active;
    logic            err;
    logic [15:0]     byte_count;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(8)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_i              (req),
        .req_data_i         (req_data),
        .tx_busy_i          (tx_busy),
        .tx_start_trigger_o (trig),
        .tx_data_o          (tx_data),
        .ack_o              (ack),
        .grant_id_o         (grant_id),
        .active_o           (active),
        .err_timeout_o      (err),
        .byte_count_o       (byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; tx_busy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_trig"},  32'(trig), 0);
        chk({tag, "_ack"},   32'(ack), 0);
        chk({tag, "_data"},  32'(tx_data), 0);
        chk({tag, "_act"},   32'(active), 0);
        chk({tag, "_err"},   32'(err), 0);
        chk({tag, "_count"}, 32'(byte_count), 0);
        chk({tag, "_gid"},   32'(grant_id), NR - 1);
    endtask

    task automatic chk_grant(input string tag, input int id, input logic [7:0] d);
        chk({tag, "_trig"}, 32'(trig), 1);
        chk({tag, "_ack"},  32'(ack), 32'(1 << id));
        chk({tag, "_gid"},  32'(grant_id), 32'(id));
        chk({tag, "_data"}, 32'(tx_data), 32'(d));
    endtask

    task automatic wait_trig(input int budget, input string tag);
        int n;
        n = 0;
        tick();
        while (!trig && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_trig_seen"}, 32'(trig), 1);
    endtask

    // called on the trigger cycle; leaves the bench on the first idle cycle after the frame
    task automatic busy_frame(input int hold, input logic [7:0] d, input string tag);
        tx_busy = 1'b1;
        repeat (hold) begin
            tick();
            chk({tag, "_hold_data"}, 32'(tx_data), 32'(d));
            chk({tag, "_hold_trig"}, 32'(trig), 0);
        end
        tx_busy = 1'b0;
        tick();
    endtask

    logic [7:0]    bytes [NR][NB];
    int            served [NR];
    int            m_last, m_k, m_frames, win, total, cyc, c;
    bit            m_in_frame, m_seen_busy, exp_trig, found, t_on;
    logic [7:0]    m_data;
    logic [NR-1:0] p_req;
    logic          p_busy;
    int            t_wait, t_hold, exp_id;
    logic [7:0]    exp_byte;

    initial begin
        rst = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // single request, one-cycle latency, frame completion
        req_data[7:0] = 8'h41; req = 4'b0001;
        tick();
        chk_grant("single", 0, 8'h41);
        chk("single_active", 32'(active), 1);
        req = '0;
        busy_frame(3, 8'h41, "single");
        chk("single_count", 32'(byte_count), 1);
        chk("single_idle", 32'(active), 0);
        chk("single_data_kept", 32'(tx_data), 32'h41);

        // contention: every requester pending
        do_reset();
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_trig(6, "rr");
            exp_id   = k % NR;
            exp_byte = req_data[8*exp_id +: 8];
            chk_grant("rr", exp_id, exp_byte);
            busy_frame(2, exp_byte, "rr");
        end
        req = '0;
        chk("rr_count", 32'(byte_count), 5);

        // transmitter never raises busy
        do_reset();
        req_data[15:8] = 8'h5A; req = 4'b0010;
        tick();
        chk_grant("tmo", 1, 8'h5A);
        req = '0;
        repeat (7) begin
            tick();
            chk("tmo_err_early", 32'(err), 0);
            chk("tmo_active", 32'(active), 1);
        end
        tick();
        chk("tmo_err", 32'(err), 1);
        chk("tmo_idle", 32'(active), 0);
        chk("tmo_count", 32'(byte_count), 0);
        req_data[7:0] = 8'h66; req = 4'b0001;
        tick();
        chk_grant("tmo_after", 0, 8'h66);
        req = '0;
        busy_frame(2, 8'h66, "tmo_after");
        chk("tmo_sticky", 32'(err), 1);
        chk("tmo_after_count", 32'(byte_count), 1);

        // reset while waiting for the frame to finish
        req_data[7:0] = 8'h77; req = 4'b0001;
        tick();
        chk_grant("mid", 0, 8'h77);
        req = '0; tx_busy = 1'b1;
        tick(); tick();
        chk("mid_active", 32'(active), 1);
        rst = 1'b1;
        tick();
        chk_reset_vals("midrst");
        rst = 1'b0; tx_busy = 1'b0;
        req_data[23:16] = 8'hC3; req = 4'b0100;
        tick();
        chk_grant("midpost", 2, 8'hC3);
        req = '0;
        busy_frame(2, 8'hC3, "midpost");
        chk("midpost_count", 32'(byte_count), 1);

        // transmitter busy while idle holds off the grant
        tx_busy = 1'b1; req_data[31:24] = 8'hD4; req = 4'b1000;
        repeat (4) begin
            tick();
            chk("bidle_no_trig", 32'(trig), 0);
            chk("bidle_no_ack", 32'(ack), 0);
        end
        tx_busy = 1'b0;
        tick();
        chk_grant("bidle", 3, 8'hD4);
        req = '0;
        busy_frame(2, 8'hD4, "bidle");

        // frame counter wrap
        force dut.byte_count_q = 16'hFFFF;
        tick();
        release dut.byte_count_q;
        tick();
        chk("wrap_preload", 32'(byte_count), 32'hFFFF);
        req_data[7:0] = 8'h99; req = 4'b0001;
        tick();
        chk_grant("wrap", 0, 8'h99);
        req = '0;
        busy_frame(2, 8'h99, "wrap");
        chk("wrap_count", 32'(byte_count), 0);

        // randomized traffic
        do_reset();
        for (int i = 0; i < NR; i++) begin
            served[i] = 0;
            for (int k = 0; k < NB; k++) bytes[i][k] = 8'($urandom);
        end
        m_last = NR - 1; m_in_frame = 0; m_seen_busy = 0; m_k = 0;
        m_frames = 0; m_data = '0; t_on = 0; total = 0; cyc = 0;
        t_wait = 0; t_hold = 0;
        while (cyc < 3000 && !(total == NR * NB && !m_in_frame && !t_on)) begin
            p_req  = req;
            p_busy = tx_busy;
            tick();
            cyc++;
            exp_trig = 0; win = 0;
            if (!m_in_frame) begin
                if (p_req != '0 && !p_busy) begin
                    found = 0;
                    for (int s = 1; s <= NR; s++) begin
                        c = (m_last + s) % NR;
                        if (!found && p_req[c]) begin
                            win = c; found = 1;
                        end
                    end
                    exp_trig = 1; m_in_frame = 1; m_k = 0; m_seen_busy = 0;
                    m_last = win; m_data = bytes[win][served[win]];
                end
            end else begin
                m_k++;
                if (m_k >= 2) begin
                    if (m_seen_busy && !p_busy) begin
                        m_in_frame = 0;
                        m_frames++;
                    end else if (p_busy) begin
                        m_seen_busy = 1;
                    end
                end
            end
            chk("rnd_trig", 32'(trig), 32'(exp_trig));
            chk("rnd_ack", 32'(ack), exp_trig ? 32'(1 << win) : 32'd0);
            chk("rnd_gid", 32'(grant_id), 32'(m_last));
            chk("rnd_data", 32'(tx_data), 32'(m_data));
            chk("rnd_active", 32'(active), 32'(m_in_frame));
            chk("rnd_count", 32'(byte_count), 32'(m_frames[15:0]));
            chk("rnd_err", 32'(err), 0);

            if (exp_trig) begin
                served[win]++; total++;
                t_wait = $urandom_range(0, 3);
                t_hold = $urandom_range(2, 5);
                t_on   = 1;
            end
            for (int i = 0; i < NR; i++) begin
                if (served[i] < NB) begin
                    req_data[8*i +: 8] = bytes[i][served[i]];
                    req[i] = ($urandom_range(0, 3) != 0);
                end else begin
                    req[i] = 1'b0;
                end
            end
            if (t_on) begin
                if (t_wait > 0) begin
                    t_wait--; tx_busy = 1'b0;
                end else if (t_hold > 0) begin
                    t_hold--; tx_busy = 1'b1;
                end else begin
                    tx_busy = 1'b0; t_on = 0;
                end
            end else begin
                tx_busy = !m_in_frame && ($urandom_range(0, 7) == 0);
            end
        end
        chk("rnd_all_served", 32'(total), NR * NB);
        tick();
        chk("rnd_final_count", 32'(byte_count), NR * NB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing one uart transmitter.
REQ-002 Parameter BUSY_TIMEOUT, default 8: clk cycles allowed between trigger and tx_busy rising.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 req  input  NUM_REQ  per-requester byte-pending flag; held high until the matching ack.
REQ-006 req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i]; stable while req[i]=1.
REQ-007 tx_busy  input  1  busy flag from the uart transmitter.
REQ-008 tx_start_trigger  output  1  one-cycle start pulse to the uart transmitter.
REQ-009 tx_data  output  8  byte to the uart transmitter; held stable for the whole frame.
REQ-010 ack  output  NUM_REQ  one-cycle pulse; the requester's byte has been latched.
REQ-011 grant_id  output  clog2(NUM_REQ)  index of the last granted requester.
REQ-012 active  output  1  high in every state except IDLE.
REQ-013 err_timeout  output  1  sticky flag; tx_busy failed to rise within BUSY_TIMEOUT.
REQ-014 byte_count  output  16  number of frames completed; wraps from 0xFFFF to 0.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-016 IDLE: when any req bit is 1 and tx_busy=0, the block SHALL select a winner, latch that requester's req_data into tx_data and grant_id, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 Winner selection SHALL be round-robin: search starts at grant_id+1 and wraps modulo NUM_REQ; the first set req bit wins.
REQ-018 ISSUE lasts exactly one cycle, with tx_start_trigger=1 and ack[winner]=1 in that cycle; the next state is WAIT_BUSY.
REQ-019 Latency: a req sampled in IDLE at cycle t SHALL give trigger and ack at cycle t+1.
REQ-020 WAIT_BUSY: tx_busy=1 SHALL move the FSM to WAIT_DONE. If tx_busy stays 0 for BUSY_TIMEOUT cycles, the block SHALL set err_timeout and return to IDLE; byte_count is not incremented.
REQ-021 WAIT_DONE: tx_busy=0 SHALL move the FSM to IDLE and increment byte_count by 1, modulo 2^16.
REQ-022 tx_data SHALL NOT change outside the IDLE to ISSUE transition, because the transmitter samples i_data on every bit.
REQ-023 req bits SHALL be ignored outside IDLE. A req dropped before it is granted SHALL produce no ack.
REQ-024 A requester that keeps req high after its ack SHALL be re-arbitrated in the next IDLE cycle; round-robin prevents it from being served twice while others wait.
REQ-025 At most one ack bit SHALL be high in any cycle, and ack SHALL be high only when tx_start_trigger is high.
REQ-026 Entering IDLE with tx_busy=1 (the transmitter is still busy) SHALL hold the block in IDLE until tx_busy=0.
REQ-027 err_timeout SHALL clear only on rst; arbitration continues normally while it is set.

Reset
REQ-028 rst SHALL force state=IDLE, tx_start_trigger=0, tx_data=0, ack=0, active=0, err_timeout=0, byte_count=0, the timeout counter=0, and grant_id=NUM_REQ-1, so requester 0 has first priority.
REQ-029 rst asserted mid-frame SHALL abort immediately with no ack, no trigger and no count change in the following cycle.
REQ-030 rst has priority over every other condition in the same cycle.

Structure
REQ-031 State encoding, the BUSY_TIMEOUT default and the NUM_REQ default SHALL live in the shared package uart_arb_pkg.
REQ-032 Round-robin selection SHALL be one combinational sub-module, rr_picker (inputs req and last grant; outputs winner index and valid).
REQ-033 The arbiter SHALL connect directly to uart tx_start_triger, tx_data and tx_busy, with no glue logic.

Verification
REQ-034 Single request: req=4'b0001 with req_data[7:0]=8'h41 -> ack[0] and trigger one cycle later, tx_data=8'h41 through the frame, byte_count=1 after tx_busy falls.
REQ-035 Contention: req=4'b1111 held, all bytes distinct -> grants in order 0,1,2,3,0; each tx_data value matches its requester.
REQ-036 Timeout: tx_busy tied to 0, req=4'b0010 -> ack[1], then err_timeout=1 eight cycles after the trigger; back to IDLE; byte_count=0.
REQ-037 Reset mid-frame: rst in WAIT_DONE -> next cycle all outputs at reset values; a following req=4'b0100 is granted normally.
REQ-038 Busy at idle: tx_busy=1 while in IDLE with req=4'b1000 -> no trigger until tx_busy=0, then trigger one cycle later.
REQ-039 Wrap: preload byte_count=16'hFFFF and complete one frame -> byte_count=16'h0000.
